uart_flit_tx: RTL

Parametrised UART transmitter that buffers wide NoC flits in an internal FIFO and serialises each flit as a sequence of standard 8-bit UART frames, LSB byte first. It sits between a router local port and the board UART pin. It generalises the earlier fixed 66-bit sender with the following features:

- configurable flit width, FIFO depth and baud rate
- a valid/ready input handshake
- exact back-pressure
- gap-free byte streaming

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_flit_fifo.sv | 50 +++++
 rtl/uart_flit_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmitter types, constants and parameter helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_ST_IDLE,
    UART_ST_LOAD,
    UART_ST_START,
    UART_ST_DATA,
    UART_ST_PARITY,
    UART_ST_STOP
  } uart_tx_state_t;

  localparam logic        UART_IDLE_LVL  = 1'b1;
  localparam int unsigned UART_DATA_BITS = 8;

  // Clock cycles per UART bit.
  function automatic int unsigned bps_cnt(input int unsigned clk, input int unsigned bps);
    return clk / bps;
  endfunction

  // Bytes needed to carry a w-bit flit.
  function automatic int unsigned nbytes(input int unsigned w);
    return (w + UART_DATA_BITS - 1) / UART_DATA_BITS;
  endfunction

endpackage

// File: rtl/uart_flit_fifo.sv
// Single-clock flit FIFO; head entry is visible on pop_data while not empty.
module uart_flit_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally (power-of-two depth); occupancy tracked by count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_flit_tx.sv
// Buffered flit-to-UART serialiser, LSB byte first, 8N1 frames.
// Optional even parity bit when UART_FLIT_TX_PARITY_EN is defined.
module uart_flit_tx
  import uart_pkg::*;
#(
  parameter int unsigned FLIT_W     = 66,
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned UART_BPS   = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  input  logic                               flit_valid,
  input  logic [FLIT_W-1:0]                  flit_data,
  output logic                               flit_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               fifo_empty,
  output logic                               tx_busy,
  output logic                               uart_txd
);

  localparam int unsigned NBYTES  = nbytes(FLIT_W);
  localparam int unsigned SH_W    = NBYTES * UART_DATA_BITS;
  localparam int unsigned BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned BAUD_W  = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam int unsigned BYTE_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned BIT_W   = $clog2(UART_DATA_BITS);

  uart_tx_state_t    state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              txd_d;
  logic              pop;
  logic              fifo_full;
  logic [FLIT_W-1:0] head;
  logic              bit_end;
`ifdef UART_FLIT_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (flit_valid),
    .push_data (flit_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign flit_ready = !fifo_full;
  assign bit_end    = (baud_q == BAUD_W'(BPS_CNT - 1));

  // Data bits leave from sh_q[0]; consecutive bytes are contiguous, so one right shift per bit.
  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    txd_d   = uart_txd;
    pop     = 1'b0;
`ifdef UART_FLIT_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != UART_ST_IDLE && state_q != UART_ST_LOAD)
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    case (state_q)
      UART_ST_IDLE: begin
        txd_d = UART_IDLE_LVL;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = SH_W'(head);
          state_d = UART_ST_LOAD;
        end
      end
      UART_ST_LOAD: begin
        byte_d  = '0;
        bit_d   = '0;
        txd_d   = ~UART_IDLE_LVL;
        state_d = UART_ST_START;
      end
      UART_ST_START: begin
        if (bit_end) begin
          bit_d   = '0;
          txd_d   = sh_q[0];
          state_d = UART_ST_DATA;
`ifdef UART_FLIT_TX_PARITY_EN
          par_d   = ^sh_q[UART_DATA_BITS-1:0];
`endif
        end
      end
      UART_ST_DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_FLIT_TX_PARITY_EN
            txd_d   = par_q;
            state_d = UART_ST_PARITY;
`else
            txd_d   = UART_IDLE_LVL;
            state_d = UART_ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
            txd_d = sh_q[1];
          end
        end
      end
`ifdef UART_FLIT_TX_PARITY_EN
      UART_ST_PARITY: begin
        if (bit_end) begin
          txd_d   = UART_IDLE_LVL;
          state_d = UART_ST_STOP;
        end
      end
`endif
      UART_ST_STOP: begin
        if (bit_end) begin
          if (byte_q != BYTE_W'(NBYTES - 1)) begin
            byte_d  = byte_q + BYTE_W'(1);
            txd_d   = ~UART_IDLE_LVL;
            state_d = UART_ST_START;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = SH_W'(head);
            txd_d   = UART_IDLE_LVL;
            state_d = UART_ST_LOAD;
          end else begin
            txd_d   = UART_IDLE_LVL;
            state_d = UART_ST_IDLE;
          end
        end
      end
      default: state_d = UART_ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= UART_ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      sh_q     <= '0;
      uart_txd <= UART_IDLE_LVL;
      tx_busy  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sh_q     <= sh_d;
      uart_txd <= txd_d;
      tx_busy  <= (state_d != UART_ST_IDLE);
    end
  end

`ifdef UART_FLIT_TX_PARITY_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) par_q <= 1'b0;
    else            par_q <= par_d;
  end
`endif

endmodule
